// File: rtl/seq_decoder.sv
// ebpc_pkg: shared widths and the decoded block type.
// seq_decoder: bit-serial decoder turning a symbol stream back into base + bit planes.
package ebpc_pkg;
  localparam int DATA_W = 8;
  localparam int BLOCK_SIZE = 8;
  localparam int PW = BLOCK_SIZE - 1;
  localparam int LW = $clog2(DATA_W);
  typedef struct packed {
    logic [DATA_W-1:0]        base;
    logic [DATA_W:0][PW-1:0]  dbp;
    logic                     flush;
  } dbp_block_t;
endpackage

module seq_decoder import ebpc_pkg::*; (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output dbp_block_t        dbp_block_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              err_o,
  output logic              idle_o
);
  localparam int PLW = $clog2(PW);
  localparam int BW = 2 * DATA_W;
  localparam int FW = $clog2(BW + 1);
  localparam int PIW = $clog2(DATA_W + 1);
  localparam int RW = LW + 1;
  localparam logic [1:0] S_BASE = 2'd0, S_DECODE = 2'd1, S_ZRUN = 2'd2, S_OUT = 2'd3;

  logic [1:0]               state_q;
  logic [BW-1:0]            buf_q, buf_nxt;
  logic [FW-1:0]            fill_q, fill_sub, fill_nxt, cons, sym_len;
  logic [PIW-1:0]           p_q, p_up;
  logic [RW-1:0]            rem_q, run_len, eff_run;
  logic [DATA_W-1:0]        base_q, top;
  logic [DATA_W:0][PW-1:0]  dbp_q;
  logic [PW-1:0]            dbx, prev, pos_bit;
  logic [PLW-1:0]           pos;
  logic last_q, err_q, is_run, force_zero, sym_ok, run_over, acc, clr, has_base;

  assign top = buf_q[BW-1 -: DATA_W];
  assign pos = top[DATA_W-6 -: PLW];
  assign pos_bit = {1'b1, {(PW-1){1'b0}}} >> pos;

  // Symbol classification from the MSB-aligned window; valid only once fill covers sym_len.
  always_comb begin
    sym_len = FW'(1 + PW);
    dbx = top[DATA_W-2 -: PW];
    is_run = 1'b0;
    force_zero = 1'b0;
    if (!top[DATA_W-1]) begin
      dbx = '0;
      if (top[DATA_W-2]) sym_len = FW'(2);
      else if (top[DATA_W-3]) begin
        sym_len = FW'(3 + LW);
        is_run = 1'b1;
      end else begin
        sym_len = top[DATA_W-4] ? FW'(5 + PLW) : FW'(5);
        dbx = top[DATA_W-4] ? (top[DATA_W-5] ? pos_bit : pos_bit | (pos_bit >> 1))
                            : (top[DATA_W-5] ? '0 : '1);
        force_zero = !top[DATA_W-4] && top[DATA_W-5];
      end
    end
  end

  assign run_len = RW'(top[DATA_W-4 -: LW]) + RW'(2);
  assign p_up = p_q + PIW'(1);
  assign prev = (p_q == PIW'(DATA_W)) ? '0 : dbp_q[p_up];
  assign run_over = run_len > RW'(p_up);
  assign eff_run = run_over ? RW'(p_up) : run_len;
  assign sym_ok = fill_q >= sym_len;
  assign has_base = fill_q >= FW'(DATA_W);
  assign cons = (state_q == S_BASE && has_base) ? FW'(DATA_W) :
                (state_q == S_DECODE && sym_ok) ? sym_len : '0;
  // Padding left after a final word is dropped, either on the flushing handshake or when too short for a base.
  assign clr = last_q && (state_q == S_OUT ? rdy_i : state_q == S_BASE && !has_base);
  assign fill_sub = fill_q - cons;
  assign rdy_o = !last_q && fill_sub <= FW'(DATA_W);
  assign acc = vld_i && rdy_o;
  assign fill_nxt = clr ? '0 : fill_sub + (acc ? FW'(DATA_W) : '0);
  assign buf_nxt = clr ? '0 : (buf_q << cons) | (acc ? {data_i, {DATA_W{1'b0}}} >> fill_sub : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_BASE;
      buf_q <= '0;
      fill_q <= '0;
      p_q <= PIW'(DATA_W);
      rem_q <= '0;
      base_q <= '0;
      dbp_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_nxt;
      fill_q <= fill_nxt;
      if (acc && last_i) last_q <= 1'b1;
      if (clr) last_q <= 1'b0;
      case (state_q)
        S_BASE: if (has_base) begin
          base_q <= top;
          p_q <= PIW'(DATA_W);
          state_q <= S_DECODE;
        end
        S_DECODE: if (sym_ok) begin
          dbp_q[p_q] <= force_zero ? '0 : dbx ^ prev;
          p_q <= p_q - PIW'(1);
          rem_q <= eff_run - RW'(1);
          if (is_run && run_over) err_q <= 1'b1;
          state_q <= (p_q == '0) ? S_OUT : (is_run && eff_run > RW'(1)) ? S_ZRUN : S_DECODE;
        end
        S_ZRUN: begin
          dbp_q[p_q] <= prev;
          p_q <= p_q - PIW'(1);
          rem_q <= rem_q - RW'(1);
          state_q <= (p_q == '0) ? S_OUT : (rem_q == RW'(1)) ? S_DECODE : S_ZRUN;
        end
        default: if (rdy_i) state_q <= S_BASE;
      endcase
    end
  end

  assign vld_o = state_q == S_OUT;
  assign err_o = err_q;
  assign idle_o = state_q == S_BASE && fill_q == '0 && !last_q;
  assign dbp_block_o.base = base_q;
  assign dbp_block_o.dbp = dbp_q;
  assign dbp_block_o.flush = vld_o && last_q;
endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: encodes random symbol streams and checks decoded blocks against
// planes rebuilt from the symbol meanings.
module tb_seq_decoder;
  import ebpc_pkg::*;
  localparam int PLW = $clog2(PW);

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic last_i = 1'b0, vld_i = 1'b0, rdy_i = 1'b0;
  logic rdy_o, vld_o, err_o, idle_o;
  dbp_block_t dbp_block_o;

  int checks = 0, passes = 0;
  bit bits_q[$];
  dbp_block_t exp_q[$];
  dbp_block_t cur;
  int mp;
  logic [PW-1:0] mpl [0:DATA_W];

  always #5 clk_i = ~clk_i;

  seq_decoder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .last_i(last_i), .vld_i(vld_i),
    .rdy_o(rdy_o), .dbp_block_o(dbp_block_o), .vld_o(vld_o), .rdy_i(rdy_i),
    .err_o(err_o), .idle_o(idle_o)
  );

  function automatic void put(int unsigned v, int n);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endfunction

  function automatic void plane(logic [PW-1:0] dbx, bit fz);
    if (mp < 0) return;
    if (fz) mpl[mp] = '0;
    else if (mp == DATA_W) mpl[mp] = dbx;
    else mpl[mp] = dbx ^ mpl[mp+1];
    mp--;
  endfunction

  function automatic void begin_block(logic [DATA_W-1:0] b);
    cur = '0;
    cur.base = b;
    put(b, DATA_W);
    mp = DATA_W;
  endfunction

  function automatic void end_block(bit fl);
    for (int i = 0; i <= DATA_W; i++) cur.dbp[i] = mpl[i];
    cur.flush = fl;
    exp_q.push_back(cur);
  endfunction

  function automatic void sym_raw(logic [PW-1:0] d); put(1, 1); put(d, PW); plane(d, 0); endfunction
  function automatic void sym_zero(); put(1, 2); plane('0, 0); endfunction
  function automatic void sym_ones(); put(0, 5); plane('1, 0); endfunction
  function automatic void sym_zp(); put(1, 5); plane('0, 1); endfunction
  function automatic void sym_pair(int pos);
    put(2, 5); put(pos, PLW); plane((PW'(3) << (PW - 2)) >> pos, 0);
  endfunction
  function automatic void sym_single(int pos);
    put(3, 5); put(pos, PLW); plane((PW'(1) << (PW - 1)) >> pos, 0);
  endfunction
  function automatic void sym_run(int r);
    put(1, 3); put(r, LW);
    for (int k = 0; k < r + 2 && mp >= 0; k++) plane('0, 0);
  endfunction

  // Final blocks open with two raw planes so the closing word cannot be buffered before the prior block drains.
  function automatic void gen_block(bit is_last);
    begin_block(DATA_W'($urandom));
    if (is_last) begin
      sym_raw(PW'($urandom));
      sym_raw(PW'($urandom));
    end
    while (mp >= 0) begin
      case ($urandom_range(0, 6))
        0: sym_raw(PW'($urandom));
        2: if (mp >= 1) sym_run($urandom_range(0, (mp - 1) > 7 ? 7 : mp - 1)); else sym_zero();
        3: sym_ones();
        4: sym_zp();
        5: sym_pair($urandom_range(0, PW - 2));
        6: sym_single($urandom_range(0, PW - 1));
        default: sym_zero();
      endcase
    end
    end_block(is_last);
  endfunction

  task automatic drive(input bit with_last);
    int n;
    logic [DATA_W-1:0] w;
    while (bits_q.size() % DATA_W != 0) bits_q.push_back(1'b0);
    n = bits_q.size() / DATA_W;
    for (int i = 0; i < n; i++) begin
      bit ok = 1'b0;
      int t = 0;
      for (int b = 0; b < DATA_W; b++) w[DATA_W-1-b] = bits_q[i*DATA_W+b];
      @(negedge clk_i);
      vld_i = 1'b1;
      data_i = w;
      last_i = with_last && i == n - 1;
      while (!ok) begin
        #2 ok = rdy_o;
        @(posedge clk_i);
        if (!ok) begin
          t++;
          if (t > 500) begin
            checks++;
            $display("FAIL drive_timeout word %0d: rdy_o=0, required 1", i);
            bits_q.delete();
            vld_i = 1'b0;
            last_i = 1'b0;
            return;
          end
          @(negedge clk_i);
        end
      end
    end
    @(negedge clk_i);
    vld_i = 1'b0;
    last_i = 1'b0;
    bits_q.delete();
  endtask

  task automatic collect(input string name, input int pct, input int hold);
    int got = 0, cyc = 0, hc = 0, n;
    n = exp_q.size();
    while (got < n) begin
      @(negedge clk_i);
      #1 cyc++;
      if (cyc > 3000) begin
        checks++;
        $display("FAIL %s_timeout: got %0d blocks, required %0d", name, got, n);
        exp_q.delete();
        rdy_i = 1'b0;
        return;
      end
      if (vld_o) begin
        checks++;
        if (dbp_block_o !== exp_q[0])
          $display("FAIL %s_block%0d: got %h, required %h", name, got, dbp_block_o, exp_q[0]);
        else passes++;
        if (got == 0 && hc < hold) begin
          rdy_i = 1'b0;
          hc++;
          if (hc == hold) begin
            checks++;
            if (rdy_o !== 1'b0) $display("FAIL %s_rdy_full: rdy_o=%b, required 0", name, rdy_o);
            else passes++;
          end
        end else rdy_i = $urandom_range(1, 100) <= pct;
        if (rdy_i) begin
          void'(exp_q.pop_front());
          got++;
        end
      end else rdy_i = 1'($urandom_range(0, 1));
    end
    @(posedge clk_i);
    #1 rdy_i = 1'b0;
  endtask

  task automatic run(input string name, input int pct, input int hold);
    fork
      drive(1'b1);
      collect(name, pct, hold);
    join
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) $display("FAIL %s: got %b, required %b", name, got, req);
    else passes++;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check_bit("reset_rdy", rdy_o, 1'b1);
    check_bit("reset_vld", vld_o, 1'b0);
    check_bit("reset_idle", idle_o, 1'b1);
    check_bit("reset_err", err_o, 1'b0);
    check_bit("reset_block_zero", dbp_block_o == '0, 1'b1);
    rst_ni = 1'b1;
  endtask

  task automatic test_basic_flush();
    begin_block(8'h05);
    sym_run(7);
    end_block(1'b1);
    run("basic_flush", 100, 0);
    @(negedge clk_i);
    check_bit("basic_idle", idle_o, 1'b1);
    check_bit("basic_err", err_o, 1'b0);
  endtask

  task automatic test_raw_run();
    begin_block(8'h00);
    sym_raw(7'h7F);
    sym_run(6);
    end_block(1'b1);
    run("raw_run", 100, 0);
  endtask

  task automatic test_backpressure();
    gen_block(1'b0);
    gen_block(1'b1);
    run("backpressure", 100, 10);
  endtask

  task automatic test_back_to_back();
    gen_block(1'b0);
    gen_block(1'b0);
    gen_block(1'b1);
    run("back_to_back", 70, 0);
    check_bit("b2b_err", err_o, 1'b0);
  endtask

  task automatic test_run_overflow();
    begin_block(8'hA5);
    repeat (5) sym_zp();
    sym_run(7);
    end_block(1'b1);
    run("overflow", 100, 0);
    check_bit("overflow_err", err_o, 1'b1);
    repeat (5) @(negedge clk_i);
    check_bit("overflow_err_sticky", err_o, 1'b1);
  endtask

  task automatic test_reset_mid_zrun();
    begin_block(8'h00);
    sym_raw(7'h55);
    sym_run(6);
    exp_q.delete();
    drive(1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_bit("zrun_busy_idle", idle_o, 1'b0);
    rst_ni = 1'b0;
    #1;
    check_bit("zrun_rst_vld", vld_o, 1'b0);
    check_bit("zrun_rst_rdy", rdy_o, 1'b1);
    check_bit("zrun_rst_idle", idle_o, 1'b1);
    check_bit("zrun_rst_err", err_o, 1'b0);
    check_bit("zrun_rst_block", dbp_block_o == '0, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (12) @(negedge clk_i);
    check_bit("zrun_no_output", vld_o, 1'b0);
    gen_block(1'b1);
    run("after_reset", 80, 0);
  endtask

  task automatic test_random();
    repeat (6) begin
      int nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) gen_block(b == nb - 1);
      run("random", $urandom_range(30, 100), 0);
    end
    check_bit("random_err", err_o, 1'b0);
    @(negedge clk_i);
    check_bit("random_idle", idle_o, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic_flush();
    test_raw_run();
    test_backpressure();
    test_back_to_back();
    test_run_overflow();
    test_reset_mid_zrun();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
